// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a combinational instruction ROM.
// Owns the program counter, registers the ROM word into InstReg, sequences
// start/halt, applies absolute and PC-relative branches with a one-cycle
// bubble, and freezes on downstream stall.
// Optional feature macro: FETCH_CYCLE_COUNT_EN (execution cycle counter).
module fetch_unit #(
    parameter int             D       = 8,
    parameter int             C       = 9,
    parameter logic [C-1:0]   HALT_OP = {C{1'b1}}
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          BranchEn,
    input  logic          BranchAbs,
    input  logic [D-1:0]  BranchTarget,
    input  logic [C-1:0]  InstIn,
    output logic [D-1:0]  ProgCtr,
    output logic [C-1:0]  InstReg,
    output logic          InstValid,
    output logic          Done,
    output logic [15:0]   CycleCount
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;

    localparam logic [D-1:0] PC_ONE = {{(D-1){1'b0}}, 1'b1};

    state_t        r_state, w_state_nxt;
    logic [D-1:0]  r_pc, w_pc_nxt;
    logic [C-1:0]  r_ir, w_ir_nxt;
    logic          r_vld, w_vld_nxt;
    logic          r_done, w_done_nxt;

    // Start only matters outside FETCH; it relaunches from address 0
    logic          w_start;
    // Live fetch edge: in FETCH and not frozen by the downstream stall
    logic          w_adv;
    logic          w_halt_hit;

    assign w_start    = (r_state != S_FETCH) && Start;
    assign w_adv      = (r_state == S_FETCH) && !Stall;
    assign w_halt_hit = w_adv && !BranchEn && (InstIn == HALT_OP);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (Start)      w_state_nxt = S_FETCH;
            S_FETCH:        if (w_halt_hit) w_state_nxt = S_HALT;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath next values; a taken branch beats a halt word in the same cycle.
    // Relative offsets are taken from the branching instruction, which sits at PC-1.
    always_comb begin
        w_pc_nxt   = r_pc;
        w_ir_nxt   = r_ir;
        w_vld_nxt  = r_vld;
        w_done_nxt = r_done;
        if (w_start) begin
            w_pc_nxt   = '0;
            w_vld_nxt  = 1'b0;
            w_done_nxt = 1'b0;
        end else if (w_adv) begin
            if (BranchEn) begin
                w_pc_nxt  = BranchAbs ? BranchTarget : (r_pc - PC_ONE + BranchTarget);
                w_vld_nxt = 1'b0;
            end else if (w_halt_hit) begin
                w_vld_nxt  = 1'b0;
                w_done_nxt = 1'b1;
            end else begin
                w_ir_nxt  = InstIn;
                w_vld_nxt = 1'b1;
                w_pc_nxt  = r_pc + PC_ONE;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc   <= '0;
            r_ir   <= '0;
            r_vld  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_pc   <= w_pc_nxt;
            r_ir   <= w_ir_nxt;
            r_vld  <= w_vld_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign ProgCtr   = r_pc;
    assign InstReg   = r_ir;
    assign InstValid = r_vld;
    assign Done      = r_done;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] r_cnt;

    // Count every FETCH edge (stalled ones too), saturating; cleared by Start
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                                   r_cnt <= '0;
        else if (w_start)                            r_cnt <= '0;
        else if (r_state == S_FETCH && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end

    assign CycleCount = r_cnt;
`else
    assign CycleCount = '0;
`endif

endmodule
